digitron_scan_ctrl: RTL and testbench

//   Scan scheduler for the 4-digit multiplexed 7-segment display (common-cathode segments, active-low digit selects).

---
 rtl/digitron_scan_ctrl_if.sv | 23 ++
 rtl/digitron_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_digitron_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/digitron_scan_ctrl_if.sv
// Display-side bundle for the 4-digit scan controller: value load handshake,
// display mode controls, and the registered segment/select pins.
interface digitron_scan_ctrl_if;
  logic        load;
  logic [15:0] digits_bcd;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic        blank_all;
  logic        load_ack;
  logic        frame_done;
  logic [7:0]  Digitron_Out;
  logic [3:0]  DigitronCS_Out;

  modport master (
    output load, digits_bcd, dp_in, lz_en, blank_all,
    input  load_ack, frame_done, Digitron_Out, DigitronCS_Out
  );

  modport slave (
    input  load, digits_bcd, dp_in, lz_en, blank_all,
    output load_ack, frame_done, Digitron_Out, DigitronCS_Out
  );
endinterface

// File: rtl/digitron_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan scheduler: per-digit slot with a blanking
// gap, tear-free value commit at frame boundaries, optional leading-zero blanking.
module digitron_scan_ctrl #(
  parameter logic [15:0] T_SLOT  = 16'd50000,
  parameter logic [15:0] T_BLANK = 16'd500
) (
  input logic                CLK,
  input logic                RSTn,
  digitron_scan_ctrl_if.slave bus
);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_slot_cnt, w_slot_cnt_next;
  logic [1:0]  r_idx, w_idx_next;
  logic        w_slot_last, w_frame_end;

  logic [15:0] r_shadow, r_pend_data;
  logic [3:0]  r_dp_shadow, r_pend_dp;
  logic        r_pend_valid;

  logic [7:0]  r_seg, w_seg_next;
  logic [3:0]  r_cs, w_cs_next;
  logic        r_load_ack, r_frame_done;

  logic [3:0]  w_digit;
  logic [3:0]  w_hi_zero;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'h3f;
      4'd1:    seg_encode = 7'h06;
      4'd2:    seg_encode = 7'h5b;
      4'd3:    seg_encode = 7'h4f;
      4'd4:    seg_encode = 7'h66;
      4'd5:    seg_encode = 7'h6d;
      4'd6:    seg_encode = 7'h7d;
      4'd7:    seg_encode = 7'h07;
      4'd8:    seg_encode = 7'h7f;
      4'd9:    seg_encode = 7'h6f;
      default: seg_encode = 7'h40;
    endcase
  endfunction

  assign w_slot_last     = (r_slot_cnt == T_SLOT - 16'd1);
  assign w_frame_end     = w_slot_last && (r_idx == 2'd3);
  assign w_slot_cnt_next = w_slot_last ? 16'd0 : r_slot_cnt + 16'd1;
  assign w_idx_next      = w_slot_last ? r_idx + 2'd1 : r_idx;

  assign w_digit = r_shadow[{r_idx, 2'b00} +: 4];

  // w_hi_zero[k]: digit k and every digit above it are zero; digit0 never blanks
  assign w_hi_zero[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
      assign w_hi_zero[gi] = ~|r_shadow[15:4*gi];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= ST_BLANK;
      r_slot_cnt <= 16'd0;
      r_idx      <= 2'd0;
    end else begin
      r_state    <= w_state_next;
      r_slot_cnt <= w_slot_cnt_next;
      r_idx      <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = (w_slot_cnt_next < T_BLANK) ? ST_BLANK : ST_SHOW;
    w_seg_next   = 8'h00;
    w_cs_next    = 4'hF;
    if (r_state == ST_SHOW && !bus.blank_all) begin
      w_cs_next  = ~(4'b0001 << r_idx);
      w_seg_next = {r_dp_shadow[r_idx],
                    (bus.lz_en && w_hi_zero[r_idx]) ? 7'h00 : seg_encode(w_digit)};
    end
  end

  // A load on the frame-end edge becomes the next pending value while the
  // previously pending one commits.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_pend_data  <= 16'h0000;
      r_pend_dp    <= 4'h0;
      r_pend_valid <= 1'b0;
      r_shadow     <= 16'h0000;
      r_dp_shadow  <= 4'h0;
      r_load_ack   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (bus.load) begin
        r_pend_data <= bus.digits_bcd;
        r_pend_dp   <= bus.dp_in;
      end
      if (w_frame_end && r_pend_valid) begin
        r_shadow    <= r_pend_data;
        r_dp_shadow <= r_pend_dp;
      end
      r_pend_valid <= bus.load | (r_pend_valid & ~w_frame_end);
      r_load_ack   <= w_frame_end & r_pend_valid;
      r_frame_done <= w_frame_end;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_seg <= 8'h00;
      r_cs  <= 4'hF;
    end else begin
      r_seg <= w_seg_next;
      r_cs  <= w_cs_next;
    end
  end

  assign bus.Digitron_Out   = r_seg;
  assign bus.DigitronCS_Out = r_cs;
  assign bus.load_ack       = r_load_ack;
  assign bus.frame_done     = r_frame_done;

endmodule

// File: tb/tb_digitron_scan_ctrl.sv
// Randomised and directed checks of the scan controller against a
// cycle-position model of the display (T_SLOT=8, T_BLANK=2).
module tb_digitron_scan_ctrl;
  localparam int TS    = 8;
  localparam int TB    = 2;
  localparam int FRAME = 4 * TS;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  digitron_scan_ctrl_if bus();

  digitron_scan_ctrl #(.T_SLOT(16'd8), .T_BLANK(16'd2)) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] seg_tab [16] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
                               8'h7f, 8'h6f, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};

  // Model: m_k edges since reset, so the counter position is m_k mod FRAME
  int          m_k;
  int          m_pos;
  logic [1:0]  m_idx;
  logic [15:0] m_shown, m_pend;
  logic [3:0]  m_dp, m_pdp;
  logic        m_pv;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_cs;
  logic        exp_ack, exp_fd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_shown = 16'h0; m_dp = 4'h0; m_pend = 16'h0; m_pdp = 4'h0; m_pv = 1'b0;
      exp_seg = 8'h00; exp_cs = 4'hF; exp_ack = 1'b0; exp_fd = 1'b0;
    end else begin
      m_pos   = m_k % FRAME;
      m_idx   = 2'(m_pos / TS);
      exp_seg = 8'h00;
      exp_cs  = 4'hF;
      if ((m_pos % TS) >= TB && !bus.blank_all) begin
        exp_cs[m_idx] = 1'b0;
        exp_seg = seg_tab[m_shown[4*m_idx +: 4]];
        if (bus.lz_en && m_idx != 2'd0 && (m_shown >> (4*m_idx)) == 16'h0) exp_seg = 8'h00;
        if (m_dp[m_idx]) exp_seg[7] = 1'b1;
      end
      exp_fd  = (m_pos == FRAME - 1);
      exp_ack = 1'b0;
      if (exp_fd && m_pv) begin
        m_shown = m_pend; m_dp = m_pdp; m_pv = 1'b0; exp_ack = 1'b1;
      end
      if (bus.load) begin
        m_pend = bus.digits_bcd; m_pdp = bus.dp_in; m_pv = 1'b1;
      end
      m_k++;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out} !== 14'h0F00) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h",
               {bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out}, 14'h0F00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out} !== {exp_ack, exp_fd, exp_cs, exp_seg}) begin
        n_fail++;
        $display("FAIL idle_scan k=%0d got=%h exp=%h", m_k,
                 {bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out}, {exp_ack, exp_fd, exp_cs, exp_seg});
      end
      if (i == 2) begin
        n_checks++;
        if ({bus.DigitronCS_Out, bus.Digitron_Out} !== 12'hE3F) begin
          n_fail++;
          $display("FAIL first_show got=%h exp=%h", {bus.DigitronCS_Out, bus.Digitron_Out}, 12'hE3F);
        end
      end
    end
  endtask

  task automatic test_load_basic();
    int acks = 0;
    bit seen_d2 = 0;
    for (int t = 0; t < 64 && (m_k % FRAME) != 12; t++) @(negedge clk);
    bus.digits_bcd = 16'h1234; bus.dp_in = 4'b0100; bus.load = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      bus.load = 1'b0;
      n_checks++;
      if ({bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out} !== {exp_ack, exp_fd, exp_cs, exp_seg}) begin
        n_fail++;
        $display("FAIL load_basic k=%0d got=%h exp=%h", m_k,
                 {bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out}, {exp_ack, exp_fd, exp_cs, exp_seg});
      end
      if (bus.load_ack) acks++;
      if (acks > 0 && bus.DigitronCS_Out == 4'b1011 && bus.Digitron_Out == 8'hDB) seen_d2 = 1;
    end
    n_checks++;
    if (acks != 1 || !seen_d2) begin
      n_fail++;
      $display("FAIL load_ack_count acks=%0d digit2_dp_seen=%0d exp acks=1 seen=1", acks, seen_d2);
    end
  endtask

  task automatic test_lz();
    bus.lz_en = 1'b1;
    bus.dp_in = 4'b0000;
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      bus.digits_bcd = (v == 0) ? 16'h0070 : 16'h0000;
      bus.load = 1'b1;
      for (int i = 0; i < 72; i++) begin
        @(negedge clk);
        bus.load = 1'b0;
        n_checks++;
        if ({bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out} !== {exp_ack, exp_fd, exp_cs, exp_seg}) begin
          n_fail++;
          $display("FAIL lz_suppress k=%0d got=%h exp=%h", m_k,
                   {bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out}, {exp_ack, exp_fd, exp_cs, exp_seg});
        end
      end
    end
    bus.lz_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    for (int t = 0; t < 64 && (m_k % FRAME) != 0; t++) @(negedge clk);
    for (int j = 0; j < 96; j++) begin
      bus.load = (j == 5 || j == 10 || j == 31);
      bus.digits_bcd = (j == 5) ? 16'h1111 : (j == 10) ? 16'h2222 : 16'h3333;
      @(negedge clk);
      n_checks++;
      if ({bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out} !== {exp_ack, exp_fd, exp_cs, exp_seg}) begin
        n_fail++;
        $display("FAIL back_to_back k=%0d got=%h exp=%h", m_k,
                 {bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out}, {exp_ack, exp_fd, exp_cs, exp_seg});
      end
      if (bus.load_ack) acks++;
    end
    bus.load = 1'b0;
    n_checks++;
    if (acks != 2) begin
      n_fail++;
      $display("FAIL b2b_ack_count got=%0d exp=2", acks);
    end
  endtask

  task automatic test_blank_all();
    for (int t = 0; t < 64 && (m_k % FRAME) != 4; t++) @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      bus.blank_all = (i < 20);
      @(negedge clk);
      n_checks++;
      if ({bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out} !== {exp_ack, exp_fd, exp_cs, exp_seg}) begin
        n_fail++;
        $display("FAIL blank_all k=%0d got=%h exp=%h", m_k,
                 {bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out}, {exp_ack, exp_fd, exp_cs, exp_seg});
      end
    end
    bus.blank_all = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.load       = ($urandom_range(7) == 0);
      bus.digits_bcd = 16'($urandom);
      bus.dp_in      = 4'($urandom);
      if ($urandom_range(31) == 0) bus.lz_en = ~bus.lz_en;
      bus.blank_all  = ($urandom_range(15) == 0);
      @(negedge clk);
      n_checks++;
      if ({bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out} !== {exp_ack, exp_fd, exp_cs, exp_seg}) begin
        n_fail++;
        $display("FAIL random k=%0d got=%h exp=%h", m_k,
                 {bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out}, {exp_ack, exp_fd, exp_cs, exp_seg});
      end
    end
    bus.load = 1'b0; bus.blank_all = 1'b0; bus.lz_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int acks = 0;
    for (int t = 0; t < 64 && (m_k % FRAME) != 14; t++) @(negedge clk);
    bus.digits_bcd = 16'h9876; bus.dp_in = 4'hF; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    for (int t = 0; t < 64 && (m_k % FRAME) != 20; t++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out} !== 14'h0F00) begin
      n_fail++;
      $display("FAIL reset_midframe got=%h exp=%h",
               {bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out}, 14'h0F00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out} !== {exp_ack, exp_fd, exp_cs, exp_seg}) begin
        n_fail++;
        $display("FAIL after_reset k=%0d got=%h exp=%h", m_k,
                 {bus.load_ack, bus.frame_done, bus.DigitronCS_Out, bus.Digitron_Out}, {exp_ack, exp_fd, exp_cs, exp_seg});
      end
      if (bus.load_ack) acks++;
    end
    n_checks++;
    if (acks != 0) begin
      n_fail++;
      $display("FAIL reset_discard acks=%0d exp=0", acks);
    end
  endtask

  initial begin
    bus.load = 1'b0; bus.digits_bcd = 16'h0; bus.dp_in = 4'h0;
    bus.lz_en = 1'b0; bus.blank_all = 1'b0;
    #1;
    test_reset();
    test_load_basic();
    test_lz();
    test_back_to_back();
    test_blank_all();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
